// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter: instruction cache and data cache share a single
// AR/R master port. Ownership is granted per burst, from the AR handshake through
// the R beat carrying rlast. Ties are broken round-robin.
module axi_read_arbiter #(
  parameter int unsigned addr_width = 64,
  parameter int unsigned data_width = 64,
  parameter int unsigned len_width  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // Instruction-cache requester
  input  logic                  ic_arvalid,
  output logic                  ic_arready,
  input  logic [addr_width-1:0] ic_araddr,
  input  logic [len_width-1:0]  ic_arlen,
  input  logic [2:0]            ic_arsize,
  input  logic [1:0]            ic_arburst,
  output logic                  ic_rvalid,
  input  logic                  ic_rready,
  output logic [data_width-1:0] ic_rdata,
  output logic                  ic_rlast,
  // Data-cache requester
  input  logic                  dc_arvalid,
  output logic                  dc_arready,
  input  logic [addr_width-1:0] dc_araddr,
  input  logic [len_width-1:0]  dc_arlen,
  input  logic [2:0]            dc_arsize,
  input  logic [1:0]            dc_arburst,
  output logic                  dc_rvalid,
  input  logic                  dc_rready,
  output logic [data_width-1:0] dc_rdata,
  output logic                  dc_rlast,
  // Memory-side master port
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [addr_width-1:0] m_axi_araddr,
  output logic [len_width-1:0]  m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [data_width-1:0] m_axi_rdata,
  input  logic                  m_axi_rlast,
  // Status
  output logic                  ic_active,
  output logic                  dc_active,
  output logic                  len_err
);

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } state_e;

  state_e               state_q, state_d;
  logic                 gnt_ic_q, gnt_ic_d;
  logic                 gnt_dc_q, gnt_dc_d;
  // Set when the data cache owned the most recent completed burst.
  logic                 last_dc_q, last_dc_d;
  logic [len_width-1:0] len_q, len_d;
  logic [len_width-1:0] beat_q, beat_d;

  logic ar_hs;
  logic r_hs;

  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign r_hs  = m_axi_rvalid && m_axi_rready;

  // Read data needs no steering; only valid/last are qualified by the grant.
  assign ic_rdata = m_axi_rdata;
  assign dc_rdata = m_axi_rdata;

  // Grant registers are only ever set outside IDLE, so they double as ownership flags.
  assign ic_active = gnt_ic_q;
  assign dc_active = gnt_dc_q;

  // State, grant and burst-tracking registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      gnt_ic_q  <= 1'b0;
      gnt_dc_q  <= 1'b0;
      last_dc_q <= 1'b1;
      len_q     <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_ic_q  <= gnt_ic_d;
      gnt_dc_q  <= gnt_dc_d;
      last_dc_q <= last_dc_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
    end
  end

  // Next-state: arbitrate in IDLE, lock the grant until the rlast handshake.
  always_comb begin
    state_d   = state_q;
    gnt_ic_d  = gnt_ic_q;
    gnt_dc_d  = gnt_dc_q;
    last_dc_d = last_dc_q;
    len_d     = len_q;
    beat_d    = beat_q;
    unique case (state_q)
      StIdle: begin
        if (ic_arvalid && dc_arvalid) begin
          // Tie goes to whoever was not served last.
          gnt_ic_d = last_dc_q;
          gnt_dc_d = !last_dc_q;
          state_d  = StAddr;
        end else if (ic_arvalid) begin
          gnt_ic_d = 1'b1;
          state_d  = StAddr;
        end else if (dc_arvalid) begin
          gnt_dc_d = 1'b1;
          state_d  = StAddr;
        end
      end
      StAddr: begin
        if (ar_hs) begin
          len_d   = m_axi_arlen;
          beat_d  = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (r_hs) begin
          beat_d = beat_q + len_width'(1);
          if (m_axi_rlast) begin
            last_dc_d = gnt_dc_q;
            gnt_ic_d  = 1'b0;
            gnt_dc_d  = 1'b0;
            state_d   = StIdle;
          end
        end
      end
      default: begin
        gnt_ic_d = 1'b0;
        gnt_dc_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  // Output steering: AR muxed from the owner in ADDR, R handshake routed in DATA.
  always_comb begin
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_arsize  = '0;
    m_axi_arburst = '0;
    m_axi_rready  = 1'b0;
    ic_arready    = 1'b0;
    dc_arready    = 1'b0;
    ic_rvalid     = 1'b0;
    dc_rvalid     = 1'b0;
    ic_rlast      = 1'b0;
    dc_rlast      = 1'b0;
    len_err       = 1'b0;
    unique case (state_q)
      StAddr: begin
        if (gnt_ic_q) begin
          m_axi_arvalid = ic_arvalid;
          m_axi_araddr  = ic_araddr;
          m_axi_arlen   = ic_arlen;
          m_axi_arsize  = ic_arsize;
          m_axi_arburst = ic_arburst;
          ic_arready    = m_axi_arready;
        end else if (gnt_dc_q) begin
          m_axi_arvalid = dc_arvalid;
          m_axi_araddr  = dc_araddr;
          m_axi_arlen   = dc_arlen;
          m_axi_arsize  = dc_arsize;
          m_axi_arburst = dc_arburst;
          dc_arready    = m_axi_arready;
        end
      end
      StData: begin
        if (gnt_ic_q) begin
          m_axi_rready = ic_rready;
          ic_rvalid    = m_axi_rvalid;
          ic_rlast     = m_axi_rlast;
        end else if (gnt_dc_q) begin
          m_axi_rready = dc_rready;
          dc_rvalid    = m_axi_rvalid;
          dc_rlast     = m_axi_rlast;
        end
        // Flag rlast on the wrong beat, or a missing rlast on the expected last beat.
        if (r_hs) begin
          len_err = m_axi_rlast ? (beat_q != len_q) : (beat_q == len_q);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_axi_read_arbiter;

  logic        clock;
  logic        reset_n;
  logic        ic_arvalid, ic_arready, ic_rvalid, ic_rready, ic_rlast;
  logic [63:0] ic_araddr, ic_rdata;
  logic [7:0]  ic_arlen;
  logic [2:0]  ic_arsize;
  logic [1:0]  ic_arburst;
  logic        dc_arvalid, dc_arready, dc_rvalid, dc_rready, dc_rlast;
  logic [63:0] dc_araddr, dc_rdata;
  logic [7:0]  dc_arlen;
  logic [2:0]  dc_arsize;
  logic [1:0]  dc_arburst;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [63:0] m_axi_araddr, m_axi_rdata;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        ic_active, dc_active, len_err;

  int n_cmp = 0;
  int n_bad = 0;

  axi_read_arbiter dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ic_arvalid   (ic_arvalid),
    .ic_arready   (ic_arready),
    .ic_araddr    (ic_araddr),
    .ic_arlen     (ic_arlen),
    .ic_arsize    (ic_arsize),
    .ic_arburst   (ic_arburst),
    .ic_rvalid    (ic_rvalid),
    .ic_rready    (ic_rready),
    .ic_rdata     (ic_rdata),
    .ic_rlast     (ic_rlast),
    .dc_arvalid   (dc_arvalid),
    .dc_arready   (dc_arready),
    .dc_araddr    (dc_araddr),
    .dc_arlen     (dc_arlen),
    .dc_arsize    (dc_arsize),
    .dc_arburst   (dc_arburst),
    .dc_rvalid    (dc_rvalid),
    .dc_rready    (dc_rready),
    .dc_rdata     (dc_rdata),
    .dc_rlast     (dc_rlast),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arlen  (m_axi_arlen),
    .m_axi_arsize (m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rlast  (m_axi_rlast),
    .ic_active    (ic_active),
    .dc_active    (dc_active),
    .len_err      (len_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Post a read request on one requester (called just after a falling edge).
  task automatic set_req(input bit is_dc, input logic [63:0] addr, input logic [7:0] len);
    if (is_dc) begin
      dc_arvalid = 1'b1; dc_araddr = addr; dc_arlen = len; dc_arsize = 3'd3; dc_arburst = 2'd1;
    end else begin
      ic_arvalid = 1'b1; ic_araddr = addr; ic_arlen = len; ic_arsize = 3'd3; ic_arburst = 2'd1;
    end
  endtask

  // Called just after a falling edge while IDLE: every handshake/status output must be low.
  task automatic idle_check(input string tag);
    logic [10:0] v;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_arready = 1'b0;
    #1;
    v = {m_axi_arvalid, m_axi_rready, ic_arready, dc_arready, ic_rvalid, dc_rvalid,
         ic_rlast, dc_rlast, ic_active, dc_active, len_err};
    n_cmp++;
    if (v !== 11'b0) begin
      n_bad++;
      $display("FAIL %s idle outputs: got %b, expected %b", tag, v, 11'b0);
    end
  endtask

  // One cycle in ADDR with memory ready: checks the AR mux and arready steering.
  task automatic addr_phase(input bit is_dc, input logic [63:0] addr, input logic [7:0] len,
                            input string tag);
    logic [3:0] exp_rdy;
    @(negedge clock);
    m_axi_arready = 1'b1;
    #1;
    n_cmp++;
    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== addr || m_axi_arlen !== len) begin
      n_bad++;
      $display("FAIL %s ar: arvalid/araddr/arlen = %b/%h/%0d, expected 1/%h/%0d",
               tag, m_axi_arvalid, m_axi_araddr, m_axi_arlen, addr, len);
    end
    exp_rdy = is_dc ? 4'b0101 : 4'b1010;
    n_cmp++;
    if ({ic_arready, dc_arready, ic_active, dc_active} !== exp_rdy) begin
      n_bad++;
      $display("FAIL %s ready/active {ic_rdy,dc_rdy,ic_act,dc_act}: got %b, expected %b",
               tag, {ic_arready, dc_arready, ic_active, dc_active}, exp_rdy);
    end
  endtask

  // Drive n_beats R beats (rlast on index rlast_idx). Optionally stall the owner's
  // rready before beat stall_at, and raise the other requester's arvalid from late_at on.
  task automatic data_phase(input bit is_dc, input int len, input int n_beats,
                            input int rlast_idx, input int stall_at, input int stall_len,
                            input int late_at, input string tag);
    logic [63:0] v, g_data;
    logic        g_rv, g_rl, o_rv, o_rdy, exp_last, exp_err;
    for (int i = 0; i < n_beats; i++) begin
      v = (is_dc ? 64'h100 : 64'h0) + 64'(i);
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clock);
          m_axi_arready = 1'b0;
          if (is_dc) begin dc_arvalid = 1'b0; dc_rready = 1'b0; ic_rready = 1'b1; end
          else       begin ic_arvalid = 1'b0; ic_rready = 1'b0; dc_rready = 1'b1; end
          m_axi_rvalid = 1'b1; m_axi_rdata = v; m_axi_rlast = (i == rlast_idx);
          #1;
          g_rv = is_dc ? dc_rvalid : ic_rvalid;
          n_cmp++;
          if (m_axi_rready !== 1'b0 || g_rv !== 1'b1) begin
            n_bad++;
            $display("FAIL %s stall %0d: m_rready/rvalid = %b/%b, expected 0/1",
                     tag, s, m_axi_rready, g_rv);
          end
        end
      end
      @(negedge clock);
      m_axi_arready = 1'b0;
      if (is_dc) dc_arvalid = 1'b0; else ic_arvalid = 1'b0;
      ic_rready = 1'b1;
      dc_rready = 1'b1;
      m_axi_rvalid = 1'b1; m_axi_rdata = v; m_axi_rlast = (i == rlast_idx);
      if (late_at >= 0 && i >= late_at) set_req(!is_dc, 64'h2000, 8'd3);
      #1;
      g_rv     = is_dc ? dc_rvalid : ic_rvalid;
      g_rl     = is_dc ? dc_rlast : ic_rlast;
      g_data   = is_dc ? dc_rdata : ic_rdata;
      o_rv     = is_dc ? ic_rvalid : dc_rvalid;
      o_rdy    = is_dc ? ic_arready : dc_arready;
      exp_last = (i == rlast_idx);
      exp_err  = (i == rlast_idx) ? (i != len) : (i == len);
      n_cmp++;
      if (g_rv !== 1'b1 || g_rl !== exp_last || g_data !== v) begin
        n_bad++;
        $display("FAIL %s beat %0d: rvalid/rlast/rdata = %b/%b/%h, expected 1/%b/%h",
                 tag, i, g_rv, g_rl, g_data, exp_last, v);
      end
      n_cmp++;
      if ({o_rv, m_axi_rready} !== 2'b01) begin
        n_bad++;
        $display("FAIL %s beat %0d other_rvalid/m_rready: got %b, expected 01",
                 tag, i, {o_rv, m_axi_rready});
      end
      n_cmp++;
      if (len_err !== exp_err) begin
        n_bad++;
        $display("FAIL %s beat %0d len_err: got %b, expected %b", tag, i, len_err, exp_err);
      end
      if (late_at >= 0 && i >= late_at) begin
        n_cmp++;
        if (o_rdy !== 1'b0) begin
          n_bad++;
          $display("FAIL %s beat %0d waiting arready: got %b, expected 0", tag, i, o_rdy);
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    ic_arvalid = 1'b0; dc_arvalid = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_arready = 1'b0;
    @(negedge clock);
    idle_check("apply_reset");
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    // Requests and memory activity held during reset must not leak through.
    reset_n = 1'b0;
    ic_arvalid = 1'b1; dc_arvalid = 1'b1; m_axi_rvalid = 1'b1; m_axi_arready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    n_cmp++;
    if ({m_axi_arvalid, m_axi_rready, ic_arready, dc_arready, ic_rvalid, dc_rvalid,
         ic_active, dc_active, len_err} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset outputs: got %b, expected 000000000",
               {m_axi_arvalid, m_axi_rready, ic_arready, dc_arready, ic_rvalid, dc_rvalid,
                ic_active, dc_active, len_err});
    end
    @(negedge clock);
    reset_n = 1'b1; ic_arvalid = 1'b0; dc_arvalid = 1'b0;
    idle_check("reset_release");
  endtask

  task automatic test_single_ic();
    @(negedge clock);
    set_req(1'b0, 64'h1000, 8'd7);
    idle_check("single_ic_n");
    addr_phase(1'b0, 64'h1000, 8'd7, "single_ic");
    data_phase(1'b0, 7, 8, 7, -1, 0, -1, "single_ic");
  endtask

  task automatic test_round_robin();
    apply_reset();
    // Simultaneous pair after reset: ic first, dc right after.
    @(negedge clock);
    set_req(1'b0, 64'h1100, 8'd1);
    set_req(1'b1, 64'h2100, 8'd2);
    idle_check("rr_tie1");
    addr_phase(1'b0, 64'h1100, 8'd1, "rr_tie1_ic");
    data_phase(1'b0, 1, 2, 1, -1, 0, -1, "rr_tie1_ic");
    @(negedge clock);
    idle_check("rr_gap");
    addr_phase(1'b1, 64'h2100, 8'd2, "rr_tie1_dc");
    data_phase(1'b1, 2, 3, 2, -1, 0, -1, "rr_tie1_dc");
    // Lone ic burst, then another pair: dc now wins.
    @(negedge clock);
    set_req(1'b0, 64'h1200, 8'd0);
    idle_check("rr_lone");
    addr_phase(1'b0, 64'h1200, 8'd0, "rr_lone_ic");
    data_phase(1'b0, 0, 1, 0, -1, 0, -1, "rr_lone_ic");
    @(negedge clock);
    set_req(1'b0, 64'h1300, 8'd1);
    set_req(1'b1, 64'h2300, 8'd1);
    idle_check("rr_tie2");
    addr_phase(1'b1, 64'h2300, 8'd1, "rr_tie2_dc");
    data_phase(1'b1, 1, 2, 1, -1, 0, -1, "rr_tie2_dc");
    @(negedge clock);
    idle_check("rr_gap2");
    addr_phase(1'b0, 64'h1300, 8'd1, "rr_tie2_ic");
    data_phase(1'b0, 1, 2, 1, -1, 0, -1, "rr_tie2_ic");
  endtask

  task automatic test_back_to_back();
    // dc arrives with 3 ic beats left; it must wait and be issued 2 cycles after rlast.
    @(negedge clock);
    set_req(1'b0, 64'h1400, 8'd7);
    idle_check("b2b_n");
    addr_phase(1'b0, 64'h1400, 8'd7, "b2b_ic");
    data_phase(1'b0, 7, 8, 7, -1, 0, 5, "b2b_ic");
    @(negedge clock);
    idle_check("b2b_gap");
    addr_phase(1'b1, 64'h2000, 8'd3, "b2b_dc");
    data_phase(1'b1, 3, 4, 3, -1, 0, -1, "b2b_dc");
  endtask

  task automatic test_rready_stall();
    @(negedge clock);
    set_req(1'b0, 64'h1500, 8'd7);
    idle_check("stall_n");
    addr_phase(1'b0, 64'h1500, 8'd7, "stall");
    data_phase(1'b0, 7, 8, 7, 3, 4, -1, "stall");
  endtask

  task automatic test_len_err();
    // Early rlast on the sixth beat of an 8-beat burst.
    @(negedge clock);
    set_req(1'b0, 64'h1600, 8'd7);
    idle_check("early_n");
    addr_phase(1'b0, 64'h1600, 8'd7, "early");
    data_phase(1'b0, 7, 6, 5, -1, 0, -1, "early");
    // Missing rlast on the expected last beat, then a late rlast.
    @(negedge clock);
    set_req(1'b1, 64'h2600, 8'd1);
    idle_check("late_n");
    addr_phase(1'b1, 64'h2600, 8'd1, "late");
    data_phase(1'b1, 1, 3, 2, -1, 0, -1, "late");
    @(negedge clock);
    idle_check("late_done");
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clock);
    set_req(1'b0, 64'h1700, 8'd7);
    idle_check("mid_n");
    addr_phase(1'b0, 64'h1700, 8'd7, "mid_ic");
    data_phase(1'b0, 7, 3, 99, -1, 0, -1, "mid_ic");
    @(negedge clock);
    reset_n = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 64'h3;
    @(negedge clock);
    #1;
    n_cmp++;
    if ({m_axi_rready, ic_rvalid, ic_rlast, ic_active, dc_active, len_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL mid_reset outputs: got %b, expected 000000",
               {m_axi_rready, ic_rvalid, ic_rlast, ic_active, dc_active, len_err});
    end
    @(negedge clock);
    reset_n = 1'b1;
    set_req(1'b1, 64'h3000, 8'd3);
    idle_check("mid_after");
    addr_phase(1'b1, 64'h3000, 8'd3, "mid_dc");
    data_phase(1'b1, 3, 4, 3, -1, 0, -1, "mid_dc");
    @(negedge clock);
    idle_check("mid_done");
  endtask

  initial begin
    ic_arvalid = 1'b0; ic_araddr = '0; ic_arlen = '0; ic_arsize = '0; ic_arburst = '0;
    ic_rready = 1'b1;
    dc_arvalid = 1'b0; dc_araddr = '0; dc_arlen = '0; dc_arsize = '0; dc_arburst = '0;
    dc_rready = 1'b1;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
    reset_n = 1'b0;
    test_reset();
    test_single_ic();
    test_round_robin();
    test_back_to_back();
    test_rready_stall();
    test_len_err();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
